pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. Operand width is split into lookahead groups, and the groups are distributed across STAGES register slices, with the carry registered between slices. It is the clocked successor to the combinational carry_look_ahead_adder. Datapath units use it to reach wide adds (up to 128 bits) at full clock rate.

Parameters:
NUMBITS, 32, operand/result width; must be divisible by GROUPBITS*STAGES (elaboration error otherwise)
GROUPBITS, 4, bits per lookahead group (generate/propagate block)
STAGES, 2, pipeline slices; latency in cycles; 1 = single registered CLA

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts operand beat this cycle
A  in  NUMBITS  operand A
B  in  NUMBITS  operand B
carryin  in  1  carry-in (add) / borrow-in (subtract)
sub  in  1  0 = A+B+carryin, 1 = A-B-carryin
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
result  out  NUMBITS  sum/difference, modulo 2^NUMBITS
carryout  out  1  carry out of MSB (subtract: 1 = no borrow)
overflow  out  1  signed two's-complement overflow

Behaviour:
- Operand prep, applied at stage 0: Beff = sub ? ~B : B; cineff = sub ? ~carryin : carryin. Subtract therefore computes A + ~B + ~carryin = A - B - carryin.
- Slice k (0..STAGES-1) covers bits [k*W +: W], where W = NUMBITS/STAGES. Each slice is a CLA built from W/GROUPBITS groups with lookahead across groups. The slice carry-out is registered and becomes the carry-in of slice k+1.
- Operand skew: the A/Beff bits of slice k are delayed k registers. Lower result bits already computed are carried forward in delay registers, so each result beat is coherent.
- overflow = carry into MSB XOR carry out of MSB. Both are computed in the last slice.
- Latency is exactly STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, when there is no backpressure.
- Flow control uses a global enable: adv = !out_valid | out_ready.
  - All pipeline registers (data and per-stage valid) load only when adv = 1.
  - in_ready = adv. This is a combinational path from out_ready, and the path is allowed.
  - A stage valid bit loads in_valid & in_ready at stage 0, and the previous stage's valid elsewhere. Bubbles propagate; they are not collapsed.
- Stall: while out_valid = 1 and out_ready = 0, result/carryout/overflow/out_valid hold stable and no beat is lost or reordered.
- Throughput: one beat per cycle when out_ready stays 1.
- Reset (reset = 0, async): every stage valid = 0, all data/carry registers = 0. So out_valid = 0, result = 0, carryout = 0, overflow = 0, and in_ready = 1. Beats in flight are discarded. After reset deasserts, the first accepted beat emerges after STAGES cycles; no stale data appears.
- Wrap-around: the result is truncated to NUMBITS bits; the excess appears only on carryout.
- Simultaneous output pop and input push in the same cycle are both legal; the pipeline advances one step.
- X on A/B/sub/carryin while in_valid = 0 must not corrupt any valid beat.

Decomposition:
- Shared package/header cla_pkg holds:
  - localparam helpers: slice width, groups per slice.
  - a parameter-legality check macro.
  - a sub/cin encoding constant (SUB_OP = 1'b1).
- One sub-module, cla_group: GROUPBITS-wide combinational lookahead block with inputs a, b, cin and outputs sum, group P, group G. Each slice instantiates W/GROUPBITS of these plus group-level carry lookahead logic.
- Pipeline and handshake stay in pipelined_cla_adder.

Test Plan:
- Default params (32/4/2), add FFFFFFFF + 00000001, carryin = 0 -> 2 cycles after accept: result = 00000000, carryout = 1, overflow = 0.
- Subtract 00000005 - 00000007, carryin = 0 -> result = FFFFFFFE, carryout = 0 (borrow), overflow = 0. Subtract 80000000 - 00000001 -> result = 7FFFFFFF, carryout = 1, overflow = 1.
- Add 7FFFFFFF + 00000001 -> result = 80000000, carryout = 0, overflow = 1. Add 0000000C + 00000006, carryin = 1 -> result = 00000013.
- Stream 4 back-to-back beats (1+1, 2+2, 3+3, 4+4), then hold out_ready = 0 for 3 cycles -> in_ready = 0 during the stall and output held at 2. After release, results 4, 6, 8 arrive in order on consecutive cycles; none lost or duplicated.
- Assert reset for one cycle while 2 beats are in flight -> out_valid = 0 immediately (asynchronous, no clock needed). After release, new beat 9 + 1 gives result = 10 exactly 2 cycles later; the old beats never appear.
- Parameter sweep:
  - NUMBITS = 128, GROUPBITS = 8, STAGES = 4: all-ones + 1 -> result = 0, carryout = 1 after 4 cycles, with carry crossing every slice boundary.
  - NUMBITS = 4, GROUPBITS = 4, STAGES = 1: C + 6 -> result = 2, carryout = 1 after 1 cycle.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    // sub input value that selects subtraction
    localparam logic SUB_OP = 1'b1;

    function automatic int unsigned slice_width(input int unsigned numbits,
                                                input int unsigned stages);
        return numbits / stages;
    endfunction

    function automatic int unsigned groups_per_slice(input int unsigned numbits,
                                                     input int unsigned groupbits,
                                                     input int unsigned stages);
        return numbits / (groupbits * stages);
    endfunction

    function automatic bit params_legal(input int unsigned numbits,
                                        input int unsigned groupbits,
                                        input int unsigned stages);
        return (numbits != 0) && (groupbits != 0) && (stages != 0) &&
               ((numbits % (groupbits * stages)) == 0);
    endfunction

endpackage

// Elaboration-time legality check; expands to a generate block inside a module body.
`define CLA_PARAM_CHECK(nb, gb, st) \
    if (!cla_pkg::params_legal(nb, gb, st)) begin : g_param_check \
        $error("NUMBITS must be a nonzero multiple of GROUPBITS*STAGES"); \
    end

// File: rtl/cla_group.sv
// GROUPBITS-wide lookahead block: bit sums plus group propagate/generate.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUPBITS = 4
) (
    input  logic [GROUPBITS-1:0] a,
    input  logic [GROUPBITS-1:0] b,
    input  logic                 cin,
    output logic [GROUPBITS-1:0] sum,
    output logic                 p,
    output logic                 g
);

    logic [GROUPBITS-1:0] bit_p;
    logic [GROUPBITS-1:0] bit_g;
    logic [GROUPBITS-1:0] carry;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Group P/G deliberately independent of cin so slice lookahead has no loop.
    always_comb begin
        p = &bit_p;
        g = 1'b0;
        for (int i = 0; i < GROUPBITS; i++) begin
            g = bit_g[i] | (bit_p[i] & g);
        end
    end

    // Per-bit carries inside the group, seeded by the group carry-in.
    always_comb begin
        carry[0] = cin;
        for (int i = 1; i < GROUPBITS; i++) begin
            carry[i] = bit_g[i-1] | (bit_p[i-1] & carry[i-1]);
        end
    end

    assign sum = bit_p ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with a valid/ready stream interface.
// Slice k adds bits [k*W +: W]; its carry is registered into slice k+1, and the
// upper operand bits ride along in skew registers until their slice is reached.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned NUMBITS   = 32,
    parameter int unsigned GROUPBITS = 4,
    parameter int unsigned STAGES    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic               carryin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow
);

    `CLA_PARAM_CHECK(NUMBITS, GROUPBITS, STAGES)

    localparam int unsigned W  = slice_width(NUMBITS, STAGES);
    localparam int unsigned NG = groups_per_slice(NUMBITS, GROUPBITS, STAGES);

    logic               adv;
    logic [STAGES-1:0]  valid_d;
    logic [STAGES-1:0]  valid_q;
    logic [NUMBITS-1:0] b_eff;
    logic               cin_eff;

    // Whole pipe moves as one; the output register frees up when popped or empty.
    assign adv       = !valid_q[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];

    assign b_eff   = (sub == SUB_OP) ? ~B : B;
    assign cin_eff = (sub == SUB_OP) ? ~carryin : carryin;

    // Stage valid bits shift on advance; bubbles are kept, not collapsed.
    always_comb begin
        valid_d = valid_q;
        if (adv) begin
            valid_d[0] = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    // Stage valid register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [W-1:0]         sa;
        logic [W-1:0]         sb;
        logic [W-1:0]         ssum;
        logic                 scin;
        logic                 load;
        logic [NG-1:0]        grp_p;
        logic [NG-1:0]        grp_g;
        logic [NG:0]          gc;
        logic [(k+1)*W-1:0]   res_d;
        logic [(k+1)*W-1:0]   res_q;
        logic                 cout_q;

        // Data only loads for real beats so idle X inputs never enter the pipe.
        if (k == 0) begin : g_in
            assign sa    = A[W-1:0];
            assign sb    = b_eff[W-1:0];
            assign scin  = cin_eff;
            assign load  = adv & in_valid;
            assign res_d = ssum;
        end else begin : g_in
            assign sa    = g_slice[k-1].g_pend.pa_q[W-1:0];
            assign sb    = g_slice[k-1].g_pend.pb_q[W-1:0];
            assign scin  = g_slice[k-1].cout_q;
            assign load  = adv & valid_q[k-1];
            assign res_d = {ssum, g_slice[k-1].res_q};
        end

        for (genvar j = 0; j < NG; j++) begin : g_grp
            cla_group #(
                .GROUPBITS(GROUPBITS)
            ) u_grp (
                .a  (sa[j*GROUPBITS +: GROUPBITS]),
                .b  (sb[j*GROUPBITS +: GROUPBITS]),
                .cin(gc[j]),
                .sum(ssum[j*GROUPBITS +: GROUPBITS]),
                .p  (grp_p[j]),
                .g  (grp_g[j])
            );
        end

        // Group-level carry lookahead across the slice.
        always_comb begin
            gc[0] = scin;
            for (int j = 0; j < NG; j++) begin
                gc[j+1] = grp_g[j] | (grp_p[j] & gc[j]);
            end
        end

        // Accumulated low result bits and the slice carry-out.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                res_q  <= '0;
                cout_q <= 1'b0;
            end else if (load) begin
                res_q  <= res_d;
                cout_q <= gc[NG];
            end
        end

        if (k < STAGES - 1) begin : g_pend
            localparam int unsigned PW = NUMBITS - (k + 1) * W;
            logic [PW-1:0] pa_d;
            logic [PW-1:0] pb_d;
            logic [PW-1:0] pa_q;
            logic [PW-1:0] pb_q;

            if (k == 0) begin : g_src
                assign pa_d = A[NUMBITS-1:W];
                assign pb_d = b_eff[NUMBITS-1:W];
            end else begin : g_src
                assign pa_d = g_slice[k-1].g_pend.pa_q[PW+W-1:W];
                assign pb_d = g_slice[k-1].g_pend.pb_q[PW+W-1:W];
            end

            // Skew registers holding operand bits for the slices still ahead.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pa_q <= '0;
                    pb_q <= '0;
                end else if (load) begin
                    pa_q <= pa_d;
                    pb_q <= pb_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic cmsb_in;
            logic ovf_q;

            // Carry into the MSB recovered from its sum bit.
            assign cmsb_in = ssum[W-1] ^ sa[W-1] ^ sb[W-1];

            // Signed overflow flag for the output beat.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ovf_q <= 1'b0;
                end else if (load) begin
                    ovf_q <= gc[NG] ^ cmsb_in;
                end
            end
        end
    end

    assign result   = g_slice[STAGES-1].res_q;
    assign carryout = g_slice[STAGES-1].cout_q;
    assign overflow = g_slice[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed, table-driven bench for pipelined_cla_adder (default, wide and tiny configs).
module tb_pipelined_cla_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    logic clk;
    logic reset;

    // default 32/4/2 instance
    logic        in_valid, in_ready, carryin, sub, out_valid, out_ready, carryout, overflow;
    logic [31:0] A, B, result;

    // 128/8/4 instance
    logic         w_in_valid, w_in_ready, w_carryin, w_sub, w_out_valid, w_out_ready;
    logic         w_carryout, w_overflow;
    logic [127:0] w_a, w_b, w_result;

    // 4/4/1 instance
    logic       t_in_valid, t_in_ready, t_carryin, t_sub, t_out_valid, t_out_ready;
    logic       t_carryout, t_overflow;
    logic [3:0] t_a, t_b, t_result;

    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs[10];

    pipelined_cla_adder u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .carryin(carryin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carryout(carryout), .overflow(overflow)
    );

    pipelined_cla_adder #(.NUMBITS(128), .GROUPBITS(8), .STAGES(4)) u_wide (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .A(w_a), .B(w_b), .carryin(w_carryin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .result(w_result), .carryout(w_carryout),
        .overflow(w_overflow)
    );

    pipelined_cla_adder #(.NUMBITS(4), .GROUPBITS(4), .STAGES(1)) u_tiny (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .A(t_a), .B(t_b), .carryin(t_carryin), .sub(t_sub), .out_valid(t_out_valid),
        .out_ready(t_out_ready), .result(t_result), .carryout(t_carryout),
        .overflow(t_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One beat through the default instance, checking latency and outputs.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; A = v.a; B = v.b; carryin = v.cin; sub = v.sub; out_ready = 1'b1;
        #1 chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0; A = 'x; B = 'x; carryin = 1'bx; sub = 1'bx;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 128'(cyc), 128'(2));
        chk({tag, " result"}, 128'(result), 128'(v.res));
        chk({tag, " carryout"}, 128'(carryout), 128'(v.co));
        chk({tag, " overflow"}, 128'(overflow), 128'(v.ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        int popped;
        int cyc;
        vec_t v;

        //           a             b             cin   sub   res           co    ov
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h0000000C, 32'h00000006, 1'b1, 1'b0, 32'h00000013, 1'b0, 1'b0};
        vecs[5] = '{32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000C, 1'b1, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[8] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vecs[9] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};

        reset = 1'b0;
        in_valid = 1'b0; A = '0; B = '0; carryin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_carryin = 1'b0; w_sub = 1'b0;
        w_out_ready = 1'b1;
        t_in_valid = 1'b0; t_a = '0; t_b = '0; t_carryin = 1'b0; t_sub = 1'b0;
        t_out_ready = 1'b1;

        // Reset state.
        #2;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset result", 128'(result), 128'(0));
        chk("reset carryout", 128'(carryout), 128'(0));
        chk("reset overflow", 128'(overflow), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(1));
        chk("reset wide out_valid", 128'(w_out_valid), 128'(0));
        chk("reset tiny out_valid", 128'(t_out_valid), 128'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Streaming with a 3-cycle output stall starting when the first result appears.
        pushed = 0;
        popped = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 4);
            in_valid  = (pushed < 4);
            A = 32'(pushed + 1); B = 32'(pushed + 1); carryin = 1'b0; sub = 1'b0;
            #1;
            if (c >= 2 && c <= 4) begin
                chk($sformatf("stall%0d in_ready", c), 128'(in_ready), 128'(0));
                chk($sformatf("stall%0d out_valid", c), 128'(out_valid), 128'(1));
                chk($sformatf("stall%0d result", c), 128'(result), 128'(2));
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream pop%0d result", popped), 128'(result),
                    128'(2 * (popped + 1)));
                chk($sformatf("stream pop%0d cycle", popped), 128'(c), 128'(5 + popped));
                popped++;
            end
            if (in_valid && in_ready) pushed++;
        end
        in_valid = 1'b0;
        chk("stream pops", 128'(popped), 128'(4));
        chk("stream drained", 128'(out_valid), 128'(0));

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; A = 32'h100; B = 32'h100; carryin = 1'b0; sub = 1'b0;
        @(negedge clk);
        A = 32'h200; B = 32'h200;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("inflight out_valid", 128'(out_valid), 128'(1));
        reset = 1'b0;
        #1;
        chk("async reset out_valid", 128'(out_valid), 128'(0));
        chk("async reset result", 128'(result), 128'(0));
        chk("async reset in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        reset = 1'b1;
        v = '{32'h00000009, 32'h00000001, 1'b0, 1'b0, 32'h0000000A, 1'b0, 1'b0};
        run_vec(v, "post_reset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("no stale beat %0d", c), 128'(out_valid), 128'(0));
        end

        // Wide config: carry ripples across every slice boundary.
        @(negedge clk);
        w_in_valid = 1'b1; w_a = '1; w_b = 128'd1; w_carryin = 1'b0; w_sub = 1'b0;
        #1 chk("wide in_ready", 128'(w_in_ready), 128'(1));
        @(negedge clk);
        w_in_valid = 1'b0;
        cyc = 1;
        while (!w_out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("wide latency", 128'(cyc), 128'(4));
        chk("wide result", w_result, 128'd0);
        chk("wide carryout", 128'(w_carryout), 128'(1));
        chk("wide overflow", 128'(w_overflow), 128'(0));

        // Tiny config: single registered CLA.
        @(negedge clk);
        t_in_valid = 1'b1; t_a = 4'hC; t_b = 4'h6; t_carryin = 1'b0; t_sub = 1'b0;
        @(negedge clk);
        t_in_valid = 1'b0;
        cyc = 1;
        while (!t_out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("tiny latency", 128'(cyc), 128'(1));
        chk("tiny result", 128'(t_result), 128'(2));
        chk("tiny carryout", 128'(t_carryout), 128'(1));
        chk("tiny overflow", 128'(t_overflow), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
